// File: rtl/page_subdivide_arb.sv
`default_nettype none
// ============================================================================
// Module   : page_subdivide_arb
// Purpose  : Routes BFT packets down to leaf pages and round-robin merges the
//            leaf replies back into one BFT stream through per-leaf FIFOs.
//            Define PAGE_SUBDIV_DROP_CNT_EN to add the drop_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module page_subdivide_arb #(
  parameter int NUM_LEAF   = 4,
  parameter int PKT_W      = 49,
  parameter int ADDR_W     = 5,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PKT_W-1:0]          din_leaf_bft2interface,
  output logic [PKT_W-1:0]          dout_leaf_interface2bft,
  input  logic                      resend,
  input  logic                      ap_start,
  output logic [NUM_LEAF*PKT_W-1:0] leaf_din,
  input  logic [NUM_LEAF*PKT_W-1:0] leaf_dout,
  output logic [NUM_LEAF-1:0]       leaf_resend,
  output logic [NUM_LEAF-1:0]       leaf_ap_start,
  output logic [NUM_LEAF-1:0]       ovf
`ifdef PAGE_SUBDIV_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int C_PTR_W = (NUM_LEAF > 1) ? $clog2(NUM_LEAF) : 1;
  localparam int C_AW    = $clog2(FIFO_DEPTH);
  localparam int C_CW    = C_AW + 1;

  logic [PKT_W-1:0]          r_mem [NUM_LEAF][FIFO_DEPTH];
  logic [C_AW-1:0]           r_wptr [NUM_LEAF];
  logic [C_AW-1:0]           r_rptr [NUM_LEAF];
  logic [C_CW-1:0]           r_cnt  [NUM_LEAF];
  logic [C_CW-1:0]           w_cnt_nxt [NUM_LEAF];
  logic [NUM_LEAF-1:0]       w_push_ok, w_pop_hit, w_ovf_hit;
  logic [C_PTR_W-1:0]        r_rr_ptr, w_pop_idx, w_rr_nxt;
  logic                      w_pop_vld;
  logic [PKT_W-1:0]          w_head, r_dout;
  logic [NUM_LEAF*PKT_W-1:0] w_leaf_din_nxt, r_leaf_din;
  logic [NUM_LEAF-1:0]       r_resend, r_ovf;
  logic                      r_ap_start;
  (* dont_touch = "true" *) logic r_keep_alive;

  logic [ADDR_W-1:0] w_dest;
  logic              w_in_vld, w_route_ok;
  int                w_leaf_k;

  assign w_in_vld   = din_leaf_bft2interface[PKT_W-1];
  assign w_dest     = din_leaf_bft2interface[PKT_W-2 -: ADDR_W];
  assign w_leaf_k   = int'(w_dest) - BASE_ADDR;
  assign w_route_ok = w_in_vld && (w_leaf_k >= 0) && (w_leaf_k < NUM_LEAF);

  for (genvar gi = 0; gi < NUM_LEAF; gi++) begin : g_route
    assign w_leaf_din_nxt[gi*PKT_W +: PKT_W] =
      (w_route_ok && (w_leaf_k == gi)) ? din_leaf_bft2interface : '0;
  end

  // Round-robin search: walk offsets high-to-low so the nearest non-empty FIFO wins.
  always_comb begin
    int t;
    t         = 0;
    w_pop_vld = 1'b0;
    w_pop_idx = '0;
    for (int o = NUM_LEAF - 1; o >= 0; o--) begin
      t = int'(r_rr_ptr) + o;
      if (t >= NUM_LEAF) t = t - NUM_LEAF;
      if (r_cnt[t] != '0) begin
        w_pop_vld = 1'b1;
        w_pop_idx = C_PTR_W'(t);
      end
    end
  end

  assign w_head   = r_mem[w_pop_idx][r_rptr[w_pop_idx]];
  assign w_rr_nxt = (w_pop_idx == C_PTR_W'(NUM_LEAF - 1)) ? '0 : w_pop_idx + C_PTR_W'(1);

  // A pop frees a slot in the same cycle, so a full FIFO being popped still accepts a push.
  always_comb begin
    for (int i = 0; i < NUM_LEAF; i++) begin
      w_pop_hit[i] = w_pop_vld && !resend && (w_pop_idx == C_PTR_W'(i));
      w_push_ok[i] = leaf_dout[i*PKT_W + PKT_W - 1] &&
                     ((r_cnt[i] != C_CW'(FIFO_DEPTH)) || w_pop_hit[i]);
      w_ovf_hit[i] = leaf_dout[i*PKT_W + PKT_W - 1] &&
                     (r_cnt[i] == C_CW'(FIFO_DEPTH)) && !w_pop_hit[i];
      w_cnt_nxt[i] = r_cnt[i] + C_CW'(w_push_ok[i]) - C_CW'(w_pop_hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LEAF; i++) begin
      if (w_push_ok[i]) r_mem[i][r_wptr[i]] <= leaf_dout[i*PKT_W +: PKT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEAF; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rr_ptr     <= '0;
      r_dout       <= '0;
      r_leaf_din   <= '0;
      r_resend     <= '0;
      r_ovf        <= '0;
      r_ap_start   <= 1'b0;
      r_keep_alive <= 1'b0;
    end else begin
      r_keep_alive <= 1'b1;
      r_ap_start   <= ap_start;
      r_leaf_din   <= w_leaf_din_nxt;
      for (int i = 0; i < NUM_LEAF; i++) begin
        if (w_push_ok[i]) r_wptr[i] <= r_wptr[i] + C_AW'(1);
        if (w_pop_hit[i]) r_rptr[i] <= r_rptr[i] + C_AW'(1);
        r_cnt[i]    <= w_cnt_nxt[i];
        r_resend[i] <= (w_cnt_nxt[i] >= C_CW'(FIFO_DEPTH - 1));
        if (w_ovf_hit[i]) r_ovf[i] <= 1'b1;
      end
      if (!resend) begin
        if (w_pop_vld) begin
          r_dout   <= w_head;
          r_rr_ptr <= w_rr_nxt;
        end else begin
          r_dout <= '0;
        end
      end
    end
  end

`ifdef PAGE_SUBDIV_DROP_CNT_EN
  logic        w_drop_in;
  logic [3:0]  w_drop_num;
  logic [16:0] w_drop_sum;
  logic [15:0] r_drop_cnt;

  assign w_drop_in = w_in_vld && !w_route_ok;

  always_comb begin
    w_drop_num = 4'(w_drop_in);
    for (int i = 0; i < NUM_LEAF; i++) w_drop_num = w_drop_num + 4'(w_ovf_hit[i]);
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_drop_cnt <= '0;
    else        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign dout_leaf_interface2bft = r_dout;
  assign leaf_din                = r_leaf_din;
  assign leaf_resend             = r_resend;
  assign ovf                     = r_ovf;
  assign leaf_ap_start           = {NUM_LEAF{r_ap_start & r_keep_alive}};

endmodule
`default_nettype wire
